// File: rtl/iter_shifter_if.sv
// Purpose: request/result bundle for iter_shifter (start, operand, amount and mode in; busy, done, result out).
// Ports: start/din/amt/mode driven by the requester; busy/done/dout driven by the shifter.
// The master modport is the requester side and the slave modport is the shifter side.
interface iter_shifter_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   amt;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  modport master (
    output start, din, amt, mode,
    input  busy, done, dout
  );

  modport slave (
    input  start, din, amt, mode,
    output busy, done, dout
  );
endinterface

// File: rtl/iter_shifter.sv
// Purpose: multi-cycle shifter (LSL/LSR/ASR/ROL) that moves the operand one bit position per clock.
// Latency: a start accepted at edge E raises done in the cycle after edge E+amt+1; the minimum period is amt+3 cycles.
// Backpressure: start is sampled only while idle and ignored while busy (including the done cycle). dout holds between results.
// Ports: clk, rst (synchronous, active-high) and bus (iter_shifter_if.slave: start/din/amt/mode in, busy/done/dout out).
module iter_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic           clk,
  input  logic           rst,
  iter_shifter_if.slave  bus
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [SHW-1:0]   count;
  logic [1:0]       mode_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] step;

  // A single-bit move of the working register in the latched mode.
  // Amounts of WIDTH or more are handled by repeating this step, so there is no saturation logic.
  always_comb begin
    step = sreg;
    case (mode_q)
      MODE_LSL: step = {sreg[WIDTH-2:0], 1'b0};
      MODE_LSR: step = {1'b0, sreg[WIDTH-1:1]};
      MODE_ASR: step = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
      MODE_ROL: step = {sreg[WIDTH-2:0], sreg[WIDTH-1]};
      default:  step = sreg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      count  <= '0;
      mode_q <= MODE_LSL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dout_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sreg   <= bus.din;
            count  <= bus.amt;
            mode_q <= bus.mode;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (count != '0) begin
            sreg  <= step;
            count <= count - SHW'(1);
          end else begin
            // The result becomes visible only here, so intermediate values never reach dout.
            dout_q <= sreg;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Purpose: self-checking bench for iter_shifter (WIDTH=8, SHW=3) using directed cases, random operations and a reference model.
// Ports: none. It instantiates iter_shifter_if and drives it from one initial block.
// Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
module tb_iter_shifter;

  localparam int W = 8;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst;

  iter_shifter_if #(.WIDTH(W), .SHW(S)) bus ();

  iter_shifter #(.WIDTH(W), .SHW(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_dout;

  // Reference model: the whole shift is computed in one arithmetic step.
  function automatic logic [W-1:0] model(logic [W-1:0] d, int a, int m);
    logic signed [W-1:0] s;
    logic [2*W-1:0]      wide;
    logic [W-1:0]        r;
    int                  k;
    case (m)
      0: begin wide = {{W{1'b0}}, d} << a; r = wide[W-1:0]; end
      1: r = d >> a;
      2: begin s = d; r = s >>> a; end
      default: begin k = a % W; wide = {d, d} >> (W - k); r = wide[W-1:0]; end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and let one edge accept it. The caller guarantees the DUT is idle.
  task automatic launch(input logic [W-1:0] d, input int a, input int m);
    bus.start = 1'b1;
    bus.din   = d;
    bus.amt   = S'(a);
    bus.mode  = 2'(m);
    tick();
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done. exp_edges is the number of edges still expected before done is visible.
  // While waiting, dout must keep the previous result.
  task automatic wait_done(input string tag, input int exp_edges, input logic [W-1:0] exp_dout);
    int n;
    bit hold_ok;
    n = 0;
    hold_ok = 1'b1;
    check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.dout !== last_dout) hold_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_edges));
    check({tag, "_dout"}, 32'(bus.dout), 32'(exp_dout));
    check({tag, "_dout_held"}, 32'(hold_ok), 32'd1);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    last_dout = exp_dout;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] d, input int a, input int m);
    launch(d, a, m);
    wait_done(tag, a + 1, model(d, a, m));
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    logic [W-1:0] rd;
    int ra;
    int rm;

    bus.start = 1'b0;
    bus.din   = '0;
    bus.amt   = '0;
    bus.mode  = '0;
    last_dout = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    rst = 1'b0;
    tick();

    // Directed cases
    run_op("lsl_b3_3", 8'hB3, 3, 0);
    check("lsl_b3_3_val", 32'(last_dout), 32'h98);
    run_op("lsr_b3_2", 8'hB3, 2, 1);
    check("lsr_b3_2_val", 32'(last_dout), 32'h2C);
    run_op("asr_b3_3", 8'hB3, 3, 2);
    check("asr_b3_3_val", 32'(last_dout), 32'hF6);
    run_op("asr_73_3", 8'h73, 3, 2);
    check("asr_73_3_val", 32'(last_dout), 32'h0E);
    run_op("rol_b3_4", 8'hB3, 4, 3);
    check("rol_b3_4_val", 32'(last_dout), 32'h3B);
    run_op("rol_81_7", 8'h81, 7, 3);
    check("rol_81_7_val", 32'(last_dout), 32'hC0);
    run_op("amt0", 8'hB3, 0, 0);
    check("amt0_val", 32'(last_dout), 32'hB3);
    run_op("lsl_ff_7", 8'hFF, 7, 0);
    check("lsl_ff_7_val", 32'(last_dout), 32'h80);

    // Reset in the middle of a running operation discards it
    launch(8'hFF, 7, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_dout", 32'(bus.dout), 32'd0);
    rst = 1'b0;
    last_dout = '0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);

    // A start pulse while busy is ignored
    launch(8'hB3, 5, 0);
    tick();
    bus.start = 1'b1;
    bus.din   = 8'h01;
    bus.amt   = 3'd0;
    bus.mode  = 2'd3;
    tick();
    bus.start = 1'b0;
    bus.din   = 8'h00;
    wait_done("ignore", 4, 8'h60);
    tick();
    check("ignore_done_pulse", 32'(bus.done), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.busy === 1'b1) seen++;
    end
    check("ignore_no_relaunch", 32'(seen), 32'd0);

    // Start held high: back-to-back operations with a period of amt+3
    bus.start = 1'b1;
    bus.din   = 8'hB3;
    bus.amt   = 3'd2;
    bus.mode  = 2'd1;
    tick();
    wait_done("b2b_first", 3, 8'h2C);
    for (int p = 0; p < 2; p++) begin
      n = 0;
      seen = 0;
      tick();
      n++;
      while (bus.done !== 1'b1 && n < 40) begin
        if (bus.dout !== last_dout) seen++;
        tick();
        n++;
      end
      check("b2b_period", 32'(n), 32'd5);
      check("b2b_hold", 32'(seen), 32'd0);
      check("b2b_dout", 32'(bus.dout), 32'h2C);
    end
    bus.start = 1'b0;
    tick();
    tick();

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom);
      ra = int'($urandom_range(0, 7));
      rm = int'($urandom_range(0, 3));
      run_op("rand", rd, ra, rm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
